// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin D flip-flop bank arbiter.
// Optional feature macro used by the arbiter: DFF_ARB_TIMEOUT_EN.
package dff_arb_pkg;

  // Arbiter FSM: IDLE (nobody granted) and OWN (one requester holds the bank)
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Width of an owner index for n requesters (at least one bit)
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the hold counter, which counts 0 .. max_hold-1 (at least one bit)
  function automatic int hold_w(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first candidate request
// found when searching ptr, ptr+1, ... (mod N_REQ), skipping masked bits.
module rr_picker #(
  parameter int N_REQ   = 4,
  parameter int OWNER_W = 2
) (
  input  logic [N_REQ-1:0]   i_req,
  input  logic [OWNER_W-1:0] i_ptr,
  input  logic [N_REQ-1:0]   i_excl,
  output logic               o_found,
  output logic [OWNER_W-1:0] o_winner
);

  logic [N_REQ-1:0] w_cand;

  // Search the candidate set starting at the round-robin pointer
  always_comb begin
    w_cand   = i_req & ~i_excl;
    o_found  = 1'b0;
    o_winner = {OWNER_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_found && w_cand[(int'(i_ptr) + k) % N_REQ]) begin
        o_found  = 1'b1;
        o_winner = OWNER_W'((int'(i_ptr) + k) % N_REQ);
      end else begin
        o_found  = o_found;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit register bank.
// The granted requester's lane is loaded into q every cycle it keeps req high.
// Optional macro DFF_ARB_TIMEOUT_EN: forces release after MAX_HOLD loads.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_HOLD = 4,
  localparam int OWNER_W  = owner_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [OWNER_W-1:0]     owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   timeout_pulse
);

  if (N_REQ < 2) begin : g_bad_n_req
    $error("dff_bank_arbiter: N_REQ must be >= 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("dff_bank_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_e         r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] r_ptr;
  logic               r_busy;
  logic [WIDTH-1:0]   r_q;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int HOLD_W = hold_w(MAX_HOLD);
  logic [HOLD_W-1:0]  r_hold;
  logic               r_tp;
`endif

  logic [OWNER_W-1:0] w_ptr_next;
  logic [OWNER_W-1:0] w_pick_ptr;
  logic [N_REQ-1:0]   w_pick_excl;
  logic [N_REQ-1:0]   w_owner_oh;
  logic [N_REQ-1:0]   w_win_oh;
  logic [OWNER_W-1:0] w_winner;
  logic               w_found;
  logic               w_owner_req;
  logic               w_timeout;
  logic               w_release;
  logic [WIDTH-1:0]   w_lane;

  // Owner-side decode and the picker's search window for this cycle
  always_comb begin
    w_owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    w_win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
    w_owner_req = req[r_owner];
    w_lane      = wdata[r_owner*WIDTH +: WIDTH];
    if (r_owner == OWNER_W'(N_REQ-1)) begin
      w_ptr_next = {OWNER_W{1'b0}};
    end else begin
      w_ptr_next = r_owner + OWNER_W'(1);
    end
    // While owning, search from just past the owner and never re-pick it;
    // on a plain release its req is low anyway, on a timeout it is evicted.
    if (r_state == ST_IDLE) begin
      w_pick_ptr  = r_ptr;
      w_pick_excl = {N_REQ{1'b0}};
    end else begin
      w_pick_ptr  = w_ptr_next;
      w_pick_excl = w_owner_oh;
    end
`ifdef DFF_ARB_TIMEOUT_EN
    w_timeout = w_owner_req && (r_hold == HOLD_W'(MAX_HOLD-1));
`else
    w_timeout = 1'b0;
`endif
    w_release = !w_owner_req || w_timeout;
  end

  rr_picker #(
    .N_REQ   (N_REQ),
    .OWNER_W (OWNER_W)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (w_pick_ptr),
    .i_excl   (w_pick_excl),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Arbiter FSM, round-robin pointer and the shared register bank
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= {N_REQ{1'b0}};
      r_owner <= {OWNER_W{1'b0}};
      r_ptr   <= {OWNER_W{1'b0}};
      r_busy  <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
`ifdef DFF_ARB_TIMEOUT_EN
      r_hold  <= {HOLD_W{1'b0}};
      r_tp    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win_oh;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_OWN;
          end else begin
            r_gnt   <= {N_REQ{1'b0}};
            r_busy  <= 1'b0;
          end
`ifdef DFF_ARB_TIMEOUT_EN
          r_hold <= {HOLD_W{1'b0}};
          r_tp   <= 1'b0;
`endif
        end
        ST_OWN: begin
          // The bank loads on every cycle the owner still requests,
          // including the cycle on which a timeout evicts it.
          if (w_owner_req) begin
            r_q <= w_lane;
          end
          if (w_release) begin
            r_ptr <= w_ptr_next;
            if (w_found) begin
              r_gnt   <= w_win_oh;
              r_owner <= w_winner;
              r_busy  <= 1'b1;
            end else begin
              r_gnt   <= {N_REQ{1'b0}};
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
`ifdef DFF_ARB_TIMEOUT_EN
            r_hold <= {HOLD_W{1'b0}};
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
`endif
          end
`ifdef DFF_ARB_TIMEOUT_EN
          r_tp <= w_timeout;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= {N_REQ{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign q     = r_q;
`ifdef DFF_ARB_TIMEOUT_EN
  assign timeout_pulse = r_tp;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// Timeout expectations follow the DFF_ARB_TIMEOUT_EN macro.
module tb_dff_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [31:0]  wdata = 32'h0;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic         busy;
  logic [7:0]   q;
  logic         timeout_pulse;

  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .wdata         (wdata),
    .gnt           (gnt),
    .owner         (owner),
    .busy          (busy),
    .q             (q),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] q;
    logic       tp;
    string      name;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] WD  = {8'h33, 8'h22, 8'h11, 8'hA5};
  localparam logic [31:0] WD2 = {8'h33, 8'h22, 8'h77, 8'hA5};
  localparam logic [31:0] WD3 = {8'h33, 8'h3C, 8'h77, 8'hA5};

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o, input logic [7:0] qv,
                              input logic tp, input string nm);
    exp_t e;
    e.gnt = g; e.owner = o; e.busy = |g; e.q = qv; e.tp = tp; e.name = nm;
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, input logic [3:0] rq, input logic [31:0] wd, input exp_t e);
    vec_t v;
    v.rst = r; v.req = rq; v.wd = wd; v.e = e;
    return v;
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input int i);
    return w[i*8 +: 8];
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input logic r, input logic [3:0] rq, input logic [31:0] wd, input exp_t e);
    exp_t x;
    @(negedge clk);
    reset = r; req = rq; wdata = wd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    n_tests++;
    if (gnt !== x.gnt || owner !== x.owner || busy !== x.busy || q !== x.q || timeout_pulse !== x.tp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b owner=%0d busy=%b q=%h tp=%b, expected gnt=%b owner=%0d busy=%b q=%h tp=%b",
               x.name, gnt, owner, busy, q, timeout_pulse, x.gnt, x.owner, x.busy, x.q, x.tp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset, first grant, single requester, handoff, mid-grant reset
    tbl.push_back(mkv(1'b0, 4'b1111, WD,  mk(4'b0000, 2'd0, 8'h00, 1'b0, "rst_a")));
    tbl.push_back(mkv(1'b0, 4'b1111, WD,  mk(4'b0000, 2'd0, 8'h00, 1'b0, "rst_b")));
    tbl.push_back(mkv(1'b1, 4'b1111, WD,  mk(4'b0001, 2'd0, 8'h00, 1'b0, "first_gnt")));
    tbl.push_back(mkv(1'b1, 4'b1111, WD,  mk(4'b0001, 2'd0, 8'hA5, 1'b0, "load0")));
    tbl.push_back(mkv(1'b1, 4'b1110, WD,  mk(4'b0010, 2'd1, 8'hA5, 1'b0, "drop0")));
    tbl.push_back(mkv(1'b1, 4'b0000, WD,  mk(4'b0000, 2'd1, 8'hA5, 1'b0, "idle_keep_owner")));
    tbl.push_back(mkv(1'b0, 4'b0000, WD,  mk(4'b0000, 2'd0, 8'h00, 1'b0, "rst_c")));
    tbl.push_back(mkv(1'b1, 4'b0001, WD,  mk(4'b0001, 2'd0, 8'h00, 1'b0, "single_gnt")));
    tbl.push_back(mkv(1'b1, 4'b0001, WD,  mk(4'b0001, 2'd0, 8'hA5, 1'b0, "single_q")));
    tbl.push_back(mkv(1'b1, 4'b0000, WD,  mk(4'b0000, 2'd0, 8'hA5, 1'b0, "single_rel")));
    tbl.push_back(mkv(1'b1, 4'b0010, WD,  mk(4'b0010, 2'd1, 8'hA5, 1'b0, "ho_gnt1")));
    tbl.push_back(mkv(1'b1, 4'b0110, WD,  mk(4'b0010, 2'd1, 8'h11, 1'b0, "ho_load1")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD2, mk(4'b0100, 2'd2, 8'h11, 1'b0, "ho_switch")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD2, mk(4'b0100, 2'd2, 8'h22, 1'b0, "ho_load2")));
    tbl.push_back(mkv(1'b1, 4'b0000, WD2, mk(4'b0000, 2'd2, 8'h22, 1'b0, "ho_rel")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD3, mk(4'b0100, 2'd2, 8'h22, 1'b0, "mg_gnt")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD3, mk(4'b0100, 2'd2, 8'h3C, 1'b0, "mg_load")));
    tbl.push_back(mkv(1'b0, 4'b0100, WD3, mk(4'b0000, 2'd0, 8'h00, 1'b0, "mg_rst")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD3, mk(4'b0100, 2'd2, 8'h00, 1'b0, "mg_regnt")));
    tbl.push_back(mkv(1'b1, 4'b0100, WD3, mk(4'b0100, 2'd2, 8'h3C, 1'b0, "mg_reload")));
    tbl.push_back(mkv(1'b1, 4'b0000, WD3, mk(4'b0000, 2'd2, 8'h3C, 1'b0, "mg_rel")));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].wd, tbl[i].e);
    end

    // fairness: all requesting, each owner drops req for one cycle after two granted cycles
    apply(1'b0, 4'b0000, WD, mk(4'b0000, 2'd0, 8'h00, 1'b0, "fair_rst"));
    apply(1'b1, 4'b1111, WD, mk(4'b0001, 2'd0, 8'h00, 1'b0, "fair_gnt0"));
    for (int k = 0; k < N; k++) begin
      apply(1'b1, 4'b1111, WD, mk(oh(k), 2'(k), lane(WD, k), 1'b0, $sformatf("fair_load%0d", k)));
      apply(1'b1, 4'b1111 & ~oh(k), WD,
            mk(oh((k + 1) % N), 2'((k + 1) % N), lane(WD, k), 1'b0, $sformatf("fair_next%0d", (k + 1) % N)));
    end

    // release on the edge where a timeout would fire: plain release, no pulse
    apply(1'b0, 4'b0000, WD, mk(4'b0000, 2'd0, 8'h00, 1'b0, "rt_rst"));
    apply(1'b1, 4'b0011, WD, mk(4'b0001, 2'd0, 8'h00, 1'b0, "rt_gnt"));
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 4'b0011, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "rt_hold"));
    end
    apply(1'b1, 4'b0010, WD, mk(4'b0010, 2'd1, 8'hA5, 1'b0, "rt_release"));

    // two requesters, req0 held: bounded by MAX_HOLD only when the timeout exists
    apply(1'b0, 4'b0000, WD, mk(4'b0000, 2'd0, 8'h00, 1'b0, "to_rst"));
    apply(1'b1, 4'b0011, WD, mk(4'b0001, 2'd0, 8'h00, 1'b0, "to_gnt0"));
    if (TO_EN) begin
      for (int c = 0; c < 3; c++) begin
        apply(1'b1, 4'b0011, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "to_hold0"));
      end
      apply(1'b1, 4'b0011, WD, mk(4'b0010, 2'd1, 8'hA5, 1'b1, "to_evict"));
      apply(1'b1, 4'b0010, WD, mk(4'b0010, 2'd1, 8'h11, 1'b0, "to_own1"));
    end else begin
      for (int c = 0; c < 9; c++) begin
        apply(1'b1, 4'b0011, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "nto_hold0"));
      end
      apply(1'b1, 4'b0010, WD, mk(4'b0010, 2'd1, 8'hA5, 1'b0, "nto_rel0"));
      apply(1'b1, 4'b0010, WD, mk(4'b0010, 2'd1, 8'h11, 1'b0, "nto_own1"));
    end

    // sole requester held: one idle bubble after eviction, then re-granted
    apply(1'b0, 4'b0000, WD, mk(4'b0000, 2'd0, 8'h00, 1'b0, "sole_rst"));
    apply(1'b1, 4'b0001, WD, mk(4'b0001, 2'd0, 8'h00, 1'b0, "sole_gnt"));
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 4'b0001, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "sole_hold"));
    end
    if (TO_EN) begin
      apply(1'b1, 4'b0001, WD, mk(4'b0000, 2'd0, 8'hA5, 1'b1, "sole_bubble"));
    end else begin
      apply(1'b1, 4'b0001, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "sole_kept"));
    end
    apply(1'b1, 4'b0001, WD, mk(4'b0001, 2'd0, 8'hA5, 1'b0, "sole_regnt"));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
